nano_mon_uart: RTL and testbench

//  Downstream monitor stage for the Nano microcontroller's status/flags/R observation port.

---
 rtl/nano_mon_uart_pkg.sv | 35 +++
 rtl/nano_mon_uart_if.sv | 34 +++
 rtl/nano_mon_uart_tx.sv | 67 ++++++
 rtl/nano_mon_uart.sv | 145 ++++++++++++++
 tb/tb_nano_mon_uart.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nano_mon_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nano_mon_pkg
// Purpose  : Shared definitions for the Nano status-monitor UART stage:
//            FSM state encoding, frame length and the layout of one captured
//            buffer entry ({OUT8B, OUT4B} packed into 12 bits).
// Config   : MON_CHECKSUM_EN adds a trailing XOR checksum byte to the frame.
// Revision : 1.0 - initial release
// ============================================================================
package nano_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Header + 8 x (OUT8B byte, tagged OUT4B byte)
    localparam int FRAME_LEN_BASE = 17;

`ifdef MON_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

    // Buffer entry sub-fields
    localparam int B8_MSB = 11;
    localparam int B8_LSB = 4;
    localparam int B4_MSB = 3;
    localparam int B4_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/nano_mon_uart_if.sv
`default_nettype none
// ============================================================================
// Module   : nano_mon_uart_if
// Purpose  : Bundle of the monitor's system-facing and host-facing signals.
//            master = the monitor itself (drives select and UART outputs),
//            slave  = the surrounding system / host side.
// Signals  : START, AUTO        launch control
//            OUT8B_I, OUT4B_I   observed CPU values for the current select
//            OUT_CTRL_O         select under scan
//            TX                 UART line, 8N1, idles high
//            BUSY, FRAME_DONE   frame status
// Revision : 1.0 - initial release
// ============================================================================
interface nano_mon_uart_if;
    logic       START;
    logic       AUTO;
    logic [7:0] OUT8B_I;
    logic [3:0] OUT4B_I;
    logic [2:0] OUT_CTRL_O;
    logic       TX;
    logic       BUSY;
    logic       FRAME_DONE;

    modport master (
        input  START, AUTO, OUT8B_I, OUT4B_I,
        output OUT_CTRL_O, TX, BUSY, FRAME_DONE
    );

    modport slave (
        output START, AUTO, OUT8B_I, OUT4B_I,
        input  OUT_CTRL_O, TX, BUSY, FRAME_DONE
    );
endinterface
`default_nettype wire

// File: rtl/nano_mon_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mon_uart_tx
// Purpose  : Byte-level 8N1 serialiser, LSB first, line idles high.
// Ports    : CLK   in   clock
//            NRST  in   asynchronous active-low reset
//            ld    in   load data; honoured only while rdy=1
//            data  in   byte to send
//            TX    out  serial line
//            rdy   out  idle, or in the last cycle of the stop bit so the
//                       next byte follows with no gap
// Revision : 1.0 - initial release
// ============================================================================
module mon_uart_tx #(
    parameter int CLK_DIV = 27
) (
    input  logic       CLK,
    input  logic       NRST,
    input  logic       ld,
    input  logic [7:0] data,
    output logic       TX,
    output logic       rdy
);
    localparam int              c_baud_w    = $clog2(CLK_DIV);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLK_DIV - 1);

    logic                r_busy;
    logic [c_baud_w-1:0] r_baud;
    logic [3:0]          r_bit;   // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]          r_shift;
    logic                r_tx;
    logic                w_bit_end;

    assign w_bit_end = (r_baud == c_baud_last);
    assign rdy       = !r_busy || (w_bit_end && (r_bit == 4'd9));
    assign TX        = r_tx;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_busy  <= 1'b0;
            r_baud  <= '0;
            r_bit   <= 4'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else if (ld && rdy) begin
            r_busy  <= 1'b1;
            r_baud  <= '0;
            r_bit   <= 4'd0;
            r_shift <= data;
            r_tx    <= 1'b0;
        end else if (r_busy) begin
            if (w_bit_end) begin
                r_baud <= '0;
                if (r_bit == 4'd9) begin
                    r_busy <= 1'b0;
                end else begin
                    r_bit <= r_bit + 4'd1;
                    // Leaving slot r_bit: next slot carries data[r_bit] or the stop bit
                    r_tx  <= (r_bit == 4'd8) ? 1'b1 : r_shift[r_bit[2:0]];
                end
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/nano_mon_uart.sv
`default_nettype none
// ============================================================================
// Module   : nano_mon_uart
// Purpose  : Sweeps the Nano OUT_CTRL select over all 8 codes, captures each
//            {OUT8B,OUT4B} pair and streams the snapshot as one UART frame:
//            header, then per select k: OUT8B byte, {0,k,OUT4B} byte.
// Ports    : CLK, NRST (async active-low), bus (nano_mon_uart_if.master)
// Params   : CLK_DIV  clock cycles per UART bit (>=2)
//            HDR_BYTE frame header byte
// Config   : MON_CHECKSUM_EN appends XOR of bytes 1..16 as an 18th byte.
// Revision : 1.0 - initial release
// ============================================================================
module nano_mon_uart
    import nano_mon_pkg::*;
#(
    parameter int       CLK_DIV  = 27,
    parameter bit [7:0] HDR_BYTE = 8'hA5
) (
    input  logic            CLK,
    input  logic            NRST,
    nano_mon_uart_if.master bus
);
    localparam logic [4:0] c_frame_len = 5'(FRAME_LEN);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_sel;
    logic        r_phase;      // 0 = select driven, 1 = capture
    logic [4:0]  r_idx;        // next byte to load
    logic [11:0] r_buf [8];
    logic        w_ld;
    logic        w_rdy;
    logic        w_tx;
    logic [2:0]  w_k;
    logic [11:0] w_entry;
    logic [7:0]  w_byte;

`ifdef MON_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    assign bus.OUT_CTRL_O = (r_state == ST_SCAN) ? r_sel : 3'd0;
    assign bus.BUSY       = (r_state == ST_SCAN) || (r_state == ST_SEND);
    assign bus.FRAME_DONE = (r_state == ST_DONE);
    assign bus.TX         = w_tx;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.START || bus.AUTO) w_state_nxt = ST_SCAN;
            ST_SCAN: if (r_phase && (r_sel == 3'd7)) w_state_nxt = ST_SEND;
            ST_SEND: begin
                // rdy with nothing left to load marks the end of the last stop bit
                if (w_rdy) begin
                    if (r_idx < c_frame_len) w_ld = 1'b1;
                    else                     w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_sel   <= 3'd0;
            r_phase <= 1'b0;
            r_idx   <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_state_nxt == ST_SCAN) begin
                        r_sel   <= 3'd0;
                        r_phase <= 1'b0;
                        r_idx   <= 5'd0;
                    end
                end
                ST_SCAN: begin
                    r_phase <= ~r_phase;
                    if (r_phase) r_sel <= r_sel + 3'd1;
                end
                ST_SEND: if (w_ld) r_idx <= r_idx + 5'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            for (int i = 0; i < 8; i++) r_buf[i] <= 12'd0;
        end else if ((r_state == ST_SCAN) && r_phase) begin
            r_buf[r_sel] <= {bus.OUT8B_I, bus.OUT4B_I};
        end
    end

    // Byte idx 2k+1 and 2k+2 both belong to entry k
    always_comb begin
        w_k     = r_idx[0] ? r_idx[3:1] : (r_idx[3:1] - 3'd1);
        w_entry = r_buf[w_k];
        w_byte  = HDR_BYTE;
        if (r_idx == 5'd0) begin
            w_byte = HDR_BYTE;
        end else if (r_idx > 5'd16) begin
`ifdef MON_CHECKSUM_EN
            w_byte = r_csum;
`else
            w_byte = 8'h00;
`endif
        end else if (r_idx[0]) begin
            w_byte = w_entry[B8_MSB:B8_LSB];
        end else begin
            w_byte = {1'b0, w_k, w_entry[B4_MSB:B4_LSB]};
        end
    end

`ifdef MON_CHECKSUM_EN
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_csum <= 8'd0;
        end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_SCAN)) begin
            r_csum <= 8'd0;
        end else if (w_ld && (r_idx != 5'd0) && (r_idx <= 5'd16)) begin
            r_csum <= r_csum ^ w_byte;
        end
    end
`endif

    mon_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .CLK  (CLK),
        .NRST (NRST),
        .ld   (w_ld),
        .data (w_byte),
        .TX   (w_tx),
        .rdy  (w_rdy)
    );
endmodule
`default_nettype wire

// File: tb/tb_nano_mon_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_nano_mon_uart
// Purpose  : Directed self-checking bench for nano_mon_uart. A small system
//            model answers OUT_CTRL_O with OUT8B=8'h10+sel, OUT4B=4'hF-sel;
//            a host-side receiver decodes TX mid-bit at 27 cycles per bit.
// Config   : MON_CHECKSUM_EN enables the checksum scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nano_mon_uart;
    logic       clk = 1'b0;
    logic       nrst;
    logic       ovr = 1'b0;     // force OUT8B=FF for sel 5
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_fall = 0;
    logic [7:0] rx [18];
    logic [7:0] c_exp [17] = '{8'hA5, 8'h10, 8'h0F, 8'h11, 8'h1E, 8'h12, 8'h2D, 8'h13, 8'h3C,
                               8'h14, 8'h4B, 8'h15, 8'h5A, 8'h16, 8'h69, 8'h17, 8'h78};

    nano_mon_uart_if bus();

    nano_mon_uart #(
        .CLK_DIV  (27),
        .HDR_BYTE (8'hA5)
    ) dut (
        .CLK  (clk),
        .NRST (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.OUT8B_I = (ovr && (bus.OUT_CTRL_O == 3'd5)) ? 8'hFF : (8'h10 + {5'd0, bus.OUT_CTRL_O});
    assign bus.OUT4B_I = 4'hF - {1'b0, bus.OUT_CTRL_O};

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns c0 = posedge count at the edge that samples START
    task automatic pulse_start(output int c0);
        @(negedge clk);
        bus.START = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic wait_tx_low(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.TX === 1'b0) begin
                ok = 1'b1;
                last_fall = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.FRAME_DONE === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic recv_byte(output logic [7:0] b, output bit ok);
        b = 8'h00;
        wait_tx_low(600, ok);
        if (!ok) return;
        repeat (13) @(negedge clk);
        if (bus.TX !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (27) @(negedge clk);
            b[i] = bus.TX;
        end
        repeat (27) @(negedge clk);
        if (bus.TX !== 1'b1) ok = 1'b0;
    endtask

    task automatic recv_frame(input int n, input bit drop_auto, output bit ok, output int first_fall);
        logic [7:0] b;
        bit         okb;
        ok = 1'b1;
        first_fall = 0;
        for (int i = 0; i < n; i++) begin
            recv_byte(b, okb);
            if (i == 0) first_fall = last_fall;
            if (drop_auto && (i == 0)) bus.AUTO = 1'b0;
            if (!okb) begin
                ok = 1'b0;
                break;
            end
            rx[i] = b;
        end
    endtask

    task automatic test_reset;
        int bad;
        nrst = 1'b0;
        bus.START = 1'b0;
        bus.AUTO  = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.TX !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", bus.TX); end
        n_vec++; if (bus.OUT_CTRL_O !== 3'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", bus.OUT_CTRL_O); end
        n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        n_vec++; if (bus.FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.FRAME_DONE); end
        nrst = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.TX !== 1'b1 || bus.BUSY !== 1'b0 || bus.FRAME_DONE !== 1'b0 || bus.OUT_CTRL_O !== 3'd0) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL idle_stable: %0d disturbed cycles, want 0", bad); end
    endtask

    task automatic test_frame;
        int c0, ff;
        bit ok;
        pulse_start(c0);
        n_vec++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL busy_after_start: got %b want 1", bus.BUSY); end
        recv_frame(17, 1'b0, ok, ff);
        n_vec++; if (!ok) begin n_err++; $display("FAIL frame_rx: receive error/timeout, want clean frame"); end
        for (int i = 0; i < 17; i++) begin
            n_vec++;
            if (rx[i] !== c_exp[i]) begin n_err++; $display("FAIL frame_byte%0d: got %02h want %02h", i, rx[i], c_exp[i]); end
        end
        wait_done(400, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL frame_done_seen: no FRAME_DONE, want pulse"); end
        n_vec++; if (cyc - c0 !== 4607) begin n_err++; $display("FAIL frame_len: got %0d want 4607", cyc - c0); end
        n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL busy_in_done: got %b want 0", bus.BUSY); end
        @(negedge clk);
        n_vec++; if (bus.FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b want 0", bus.FRAME_DONE); end
    endtask

    task automatic test_timing_restart;
        int c0, c1, t1, dn;
        bit ok;
        pulse_start(c0);
        wait_tx_low(100, ok);
        n_vec++; if (!ok || (last_fall - c0 !== 17)) begin n_err++; $display("FAIL start_latency: got %0d want 17", last_fall - c0); end
        t1 = last_fall;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.TX === 1'b1) begin t1 = cyc; break; end
        end
        // Header A5 has d0=1, so the low run is exactly the start bit
        n_vec++; if (t1 - last_fall !== 27) begin n_err++; $display("FAIL bit_period: got %0d want 27", t1 - last_fall); end
        repeat (2000) @(negedge clk);
        n_vec++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL busy_midframe: got %b want 1", bus.BUSY); end
        pulse_start(c1);
        dn = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (bus.FRAME_DONE === 1'b1) dn++;
        end
        n_vec++; if (dn !== 1) begin n_err++; $display("FAIL start_while_busy: got %0d FRAME_DONE pulses want 1", dn); end
        n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL busy_after_restart: got %b want 0", bus.BUSY); end
    endtask

    task automatic test_auto;
        int ff, f;
        int bad;
        bit ok;
        @(negedge clk);
        bus.AUTO = 1'b1;
        recv_frame(17, 1'b0, ok, ff);
        n_vec++; if (!ok) begin n_err++; $display("FAIL auto_rx1: receive error/timeout, want clean frame"); end
        for (int i = 0; i < 17; i++) begin
            n_vec++;
            if (rx[i] !== c_exp[i]) begin n_err++; $display("FAIL auto1_byte%0d: got %02h want %02h", i, rx[i], c_exp[i]); end
            rx[i] = 8'h00;
        end
        wait_done(400, ok);
        @(negedge clk);
        f = cyc;
        n_vec++; if (bus.FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL auto_done_width: got %b want 0", bus.FRAME_DONE); end
        // AUTO is dropped after the header of this second frame
        recv_frame(17, 1'b1, ok, ff);
        n_vec++; if (!ok) begin n_err++; $display("FAIL auto_rx2: receive error/timeout, want clean frame"); end
        n_vec++; if (ff - f !== 18) begin n_err++; $display("FAIL auto_gap: got %0d want 18", ff - f); end
        for (int i = 0; i < 17; i++) begin
            n_vec++;
            if (rx[i] !== c_exp[i]) begin n_err++; $display("FAIL auto2_byte%0d: got %02h want %02h", i, rx[i], c_exp[i]); end
        end
        wait_done(400, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL auto_done2: no FRAME_DONE, want pulse"); end
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.BUSY !== 1'b0 || bus.TX !== 1'b1) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL auto_stop: %0d active cycles after AUTO fell, want 0", bad); end
    endtask

    task automatic test_reset_midframe;
        int c0, ff;
        bit ok;
        pulse_start(c0);
        recv_frame(5, 1'b0, ok, ff);
        wait_tx_low(600, ok);
        repeat (4 * 27 + 13) @(negedge clk);
        // Byte 5 is 8'h12: d3 = 0
        n_vec++; if (bus.TX !== 1'b0) begin n_err++; $display("FAIL byte5_d3: got %b want 0", bus.TX); end
        nrst = 1'b0;
        #1;
        n_vec++; if (bus.TX !== 1'b1) begin n_err++; $display("FAIL async_reset_tx: got %b want 1", bus.TX); end
        n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL async_reset_busy: got %b want 0", bus.BUSY); end
        @(negedge clk);
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        pulse_start(c0);
        recv_frame(17, 1'b0, ok, ff);
        n_vec++; if (!ok) begin n_err++; $display("FAIL post_reset_rx: receive error/timeout, want clean frame"); end
        for (int i = 0; i < 17; i++) begin
            n_vec++;
            if (rx[i] !== c_exp[i]) begin n_err++; $display("FAIL post_reset_byte%0d: got %02h want %02h", i, rx[i], c_exp[i]); end
        end
        wait_done(400, ok);
    endtask

`ifdef MON_CHECKSUM_EN
    task automatic test_checksum;
        int c0, ff;
        bit ok;
        pulse_start(c0);
        recv_frame(18, 1'b0, ok, ff);
        n_vec++; if (!ok) begin n_err++; $display("FAIL csum_rx: receive error/timeout, want 18 bytes"); end
        n_vec++; if (rx[16] !== 8'h78) begin n_err++; $display("FAIL csum_byte16: got %02h want 78", rx[16]); end
        n_vec++; if (rx[17] !== 8'h00) begin n_err++; $display("FAIL csum_plain: got %02h want 00", rx[17]); end
        wait_done(400, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL csum_done: no FRAME_DONE, want pulse"); end
        ovr = 1'b1;
        pulse_start(c0);
        recv_frame(18, 1'b0, ok, ff);
        n_vec++; if (rx[11] !== 8'hFF) begin n_err++; $display("FAIL csum_byte11: got %02h want FF", rx[11]); end
        n_vec++; if (rx[17] !== 8'hEA) begin n_err++; $display("FAIL csum_ovr: got %02h want EA", rx[17]); end
        wait_done(400, ok);
        ovr = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_timing_restart();
        test_auto();
        test_reset_midframe();
`ifdef MON_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
